// File: rtl/sw_cond_pkg.sv
// Shared constants for the slide-switch conditioning path.
package sw_cond_pkg;
  localparam int SW_WIDTH                   = 10;
  localparam int SW_DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int SW_CNT_W                   = 24;
  localparam int SIM_DEBOUNCE_CYCLES        = 4;
endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchronizer, persistence counter, stable flop and
// registered rise/fall pulses that coincide with the stable update.
module sw_debounce_bit
  import sw_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = SW_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_d_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any agreement with the accepted value restarts the persistence window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign edge_d_o = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce_sync.sv
// Switch bus conditioner: per-bit debounce lanes plus a bus-wide change pulse
// registered alongside the per-bit pulses.
module sw_debounce_sync
  import sw_cond_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = SW_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  logic [WIDTH-1:0] edge_d;
  logic             changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (sw_raw[i]),
      .stable_o(sw_stable[i]),
      .rise_o  (sw_rise[i]),
      .fall_o  (sw_fall[i]),
      .edge_d_o(edge_d[i])
    );
  end

  // Built from the lanes' next-state pulses so it lands in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) changed_q <= 1'b0;
    else       changed_q <= |edge_d;
  end

  assign sw_changed = changed_q;

endmodule
